// File: rtl/fifo_rd_drain_if.sv
// fifo_rd_drain_if
// Bundles the two handshakes seen by the read-side drain engine:
//   FIFO read port : i_empty, i_r_data (from FIFO), o_r_inc (to FIFO)
//   output stream  : o_valid, o_data (to consumer), i_ready (from consumer)
// Signal names keep the drain engine's point of view, so "i_" means
// "into the drain engine" and "o_" means "out of the drain engine".
// Modports:
//   master - the drain engine (fifo_rd_drain)
//   slave  - the surrounding FIFO + consumer (or a testbench playing both)
// Parameter D_SIZE is the data width and must match the drain engine.

`timescale 1ns/1ps

interface fifo_rd_drain_if #(
    parameter int D_SIZE = 16
) ();

    logic              i_empty;
    logic [D_SIZE-1:0] i_r_data;
    logic              o_r_inc;
    logic              o_valid;
    logic [D_SIZE-1:0] o_data;
    logic              i_ready;

    modport master (
        input  i_empty,
        input  i_r_data,
        input  i_ready,
        output o_r_inc,
        output o_valid,
        output o_data
    );

    modport slave (
        output i_empty,
        output i_r_data,
        output i_ready,
        input  o_r_inc,
        input  o_valid,
        input  o_data
    );

endinterface

// File: rtl/fifo_rd_drain.sv
// fifo_rd_drain
// Read-domain consumer for the asynchronous FIFO. A start command loads a
// word count; the block then pops that many words from the FIFO read port
// and forwards them in order to a valid/ready stream through a 2-entry
// registered buffer, and pulses o_done once the buffer has fully drained.
//
// Ports:
//   r_clk      - read-domain clock, rising edge
//   i_r_rstn   - asynchronous active-low reset
//   i_start    - start pulse, only honoured in IDLE
//   i_len      - burst length in words, captured with i_start
//   rd         - fifo_rd_drain_if.master: FIFO read port + output stream
//   o_busy     - high while a burst is in progress (READ or DRAIN)
//   o_done     - one-cycle pulse on the first IDLE cycle after a burst,
//                or the cycle after a zero-length start
//   o_rd_count - 16-bit wrapping count of words popped since reset,
//                only present when FIFO_RD_CNT_EN is defined
//
// Optional feature macro: FIFO_RD_CNT_EN (adds o_rd_count).

`timescale 1ns/1ps

module fifo_rd_drain #(
    parameter int D_SIZE = 16,
    parameter int L_SIZE = 8
) (
    input  logic              r_clk,
    input  logic              i_r_rstn,
    input  logic              i_start,
    input  logic [L_SIZE-1:0] i_len,
    fifo_rd_drain_if.master   rd,
    output logic              o_busy,
    output logic              o_done
`ifdef FIFO_RD_CNT_EN
    ,
    output logic [15:0]       o_rd_count
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t            state;
    logic [L_SIZE-1:0] rem;
    logic [1:0]        cnt;
    logic [1:0]        cnt_next;
    logic [D_SIZE-1:0] entry0;
    logic [D_SIZE-1:0] entry1;
    logic              pop;
    logic              accept;
    logic              valid;

    // Pop only while reading, with data available, words still owed and
    // room in the buffer. Being combinational, this is forced low in IDLE.
    assign pop    = (state == READ) && !rd.i_empty && (rem != '0) && (cnt < 2'd2);
    assign valid  = (cnt != 2'd0);
    assign accept = valid && rd.i_ready;

    assign rd.o_r_inc = pop;
    assign rd.o_valid = valid;
    assign rd.o_data  = entry0;
    assign o_busy     = (state != IDLE);

    // Buffer occupancy after this edge.
    always_comb begin
        cnt_next = cnt;
        case ({pop, accept})
            2'b10:   cnt_next = cnt + 2'd1;
            2'b01:   cnt_next = cnt - 2'd1;
            default: cnt_next = cnt;
        endcase
    end

    // Control FSM: burst length bookkeeping and the registered done pulse.
    // READ ends on the edge that takes the last word; DRAIN ends on the edge
    // that empties the buffer, so o_done lands on the first IDLE cycle.
    always_ff @(posedge r_clk or negedge i_r_rstn) begin
        if (!i_r_rstn) begin
            state  <= IDLE;
            rem    <= '0;
            o_done <= 1'b0;
        end else begin
            o_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_start) begin
                        if (i_len != '0) begin
                            rem   <= i_len;
                            state <= READ;
                        end else begin
                            o_done <= 1'b1;
                        end
                    end
                end
                READ: begin
                    if (pop) begin
                        rem <= rem - L_SIZE'(1);
                        if (rem == L_SIZE'(1)) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (cnt_next == 2'd0) begin
                        state  <= IDLE;
                        o_done <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Two-entry buffer kept as a tiny shift queue: entry0 is always the
    // head, so o_data needs no mux. A popped word lands in the first free
    // slot after any same-cycle accept has shifted the queue.
    always_ff @(posedge r_clk or negedge i_r_rstn) begin
        if (!i_r_rstn) begin
            entry0 <= '0;
            entry1 <= '0;
            cnt    <= 2'd0;
        end else begin
            cnt <= cnt_next;
            if (pop && !accept) begin
                if (cnt == 2'd0) begin
                    entry0 <= rd.i_r_data;
                end else begin
                    entry1 <= rd.i_r_data;
                end
            end else if (!pop && accept) begin
                entry0 <= entry1;
            end else if (pop && accept) begin
                if (cnt == 2'd2) begin
                    entry0 <= entry1;
                    entry1 <= rd.i_r_data;
                end else begin
                    entry0 <= rd.i_r_data;
                end
            end
        end
    end

`ifdef FIFO_RD_CNT_EN
    // Lifetime pop counter; wraps naturally at 16 bits, cleared only by reset.
    always_ff @(posedge r_clk or negedge i_r_rstn) begin
        if (!i_r_rstn) begin
            o_rd_count <= 16'd0;
        end else if (pop) begin
            o_rd_count <= o_rd_count + 16'd1;
        end
    end
`else
    // No pop counter in this build.
`endif

endmodule

// File: tb/tb_fifo_rd_drain.sv
// tb_fifo_rd_drain
// Testbench for fifo_rd_drain. The bench models the FIFO as a queue
// (i_empty / i_r_data follow the queue head, o_r_inc pops it) and plays the
// downstream consumer through i_ready. A per-cycle vector table covers
// zero-length start, a basic burst and backpressure; hand-written sequences
// cover FIFO-empty stalls, a start during READ, reset mid-burst and, when
// FIFO_RD_CNT_EN is defined, the pop counter including its 16-bit wrap.

`timescale 1ns/1ps

module tb_fifo_rd_drain;

    logic        r_clk;
    logic        i_r_rstn;
    logic        i_start;
    logic [7:0]  i_len;
    logic        o_busy;
    logic        o_done;
`ifdef FIFO_RD_CNT_EN
    logic [15:0] rd_count;
`endif

    fifo_rd_drain_if #(.D_SIZE(16)) rif ();

    fifo_rd_drain #(.D_SIZE(16), .L_SIZE(8)) dut (
        .r_clk    (r_clk),
        .i_r_rstn (i_r_rstn),
        .i_start  (i_start),
        .i_len    (i_len),
        .rd       (rif),
        .o_busy   (o_busy),
        .o_done   (o_done)
`ifdef FIFO_RD_CNT_EN
        ,
        .o_rd_count (rd_count)
`endif
    );

    typedef struct {
        int          push_n;
        logic [15:0] push_base;
        logic        start;
        logic [7:0]  len;
        logic        ready;
        logic        e_inc;
        logic        e_valid;
        logic [15:0] e_data;
        logic        e_busy;
        logic        e_done;
    } vec_t;

    vec_t        vecs[$];
    logic [15:0] fifo_q[$];
    logic [15:0] got_q[$];
    int          n_checks;
    int          n_miss;
    int          pops;
    int          total_pops;
    int          dones;
    logic        inc_seen;
    logic        acc_seen;
    logic        done_seen;
    logic [15:0] acc_data;
    logic [15:0] dummy;

    initial r_clk = 1'b0;
    always #5 r_clk = ~r_clk;

    // Bound on the whole run so a stuck design cannot hang the simulation.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_miss++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    task automatic refresh_fifo();
        rif.i_empty  = (fifo_q.size() == 0);
        rif.i_r_data = (fifo_q.size() != 0) ? fifo_q[0] : 16'h0000;
    endtask

    task automatic push_words(input int n, input logic [15:0] base);
        for (int i = 0; i < n; i++) begin
            fifo_q.push_back(base + 16'(i));
        end
        refresh_fifo();
    endtask

    // Called between the negedge and the next posedge: snapshot this cycle's
    // handshakes, cross the edge, then update the FIFO model and scoreboard.
    task automatic finish_cycle();
        inc_seen  = rif.o_r_inc;
        acc_seen  = rif.o_valid && rif.i_ready;
        acc_data  = rif.o_data;
        done_seen = o_done;
        @(posedge r_clk);
        #1;
        if (inc_seen) begin
            dummy = fifo_q.pop_front();
            pops++;
            total_pops++;
        end
        if (acc_seen) got_q.push_back(acc_data);
        if (done_seen) dones++;
        refresh_fifo();
    endtask

    task automatic cycle_mon();
        @(negedge r_clk);
        check_output("inc_while_empty", {31'd0, rif.o_r_inc && rif.i_empty}, 32'd0);
        finish_cycle();
    endtask

    task automatic apply_stimulus(input vec_t v);
        if (v.push_n > 0) push_words(v.push_n, v.push_base);
        i_start     = v.start;
        i_len       = v.len;
        rif.i_ready = v.ready;
    endtask

    task automatic clear_stats();
        pops  = 0;
        dones = 0;
        got_q.delete();
    endtask

    task automatic check_got(input string name, input int n, input logic [15:0] base);
        check_output({name, "_count"}, got_q.size(), n);
        for (int i = 0; i < n; i++) begin
            check_output($sformatf("%s_word%0d", name, i),
                         (i < got_q.size()) ? {16'd0, got_q[i]} : 32'hDEAD_BEEF,
                         {16'd0, base + 16'(i)});
        end
    endtask

    task automatic run_burst(input int len, input logic [15:0] base);
        push_words(len, base);
        i_start = 1'b1;
        i_len   = 8'(len);
        cycle_mon();
        i_start = 1'b0;
        repeat (len + 2) cycle_mon();
    endtask

    function automatic void add_vec(int push_n, logic [15:0] push_base, logic start,
                                    logic [7:0] len, logic ready, logic e_inc,
                                    logic e_valid, logic [15:0] e_data, logic e_busy,
                                    logic e_done);
        vec_t v;
        v.push_n    = push_n;
        v.push_base = push_base;
        v.start     = start;
        v.len       = len;
        v.ready     = ready;
        v.e_inc     = e_inc;
        v.e_valid   = e_valid;
        v.e_data    = e_data;
        v.e_busy    = e_busy;
        v.e_done    = e_done;
        vecs.push_back(v);
    endfunction

    initial begin
        n_checks   = 0;
        n_miss     = 0;
        total_pops = 0;
        clear_stats();

        // One row per clock cycle: push, start, len, ready, then expected
        // o_r_inc, o_valid, o_data (checked only when valid), o_busy, o_done.
        // Zero-length start: done next cycle, no pops.
        add_vec(0, 16'h0000, 1, 8'd0, 1, 0, 0, 16'h0000, 0, 0);
        add_vec(0, 16'h0000, 0, 8'd0, 1, 0, 0, 16'h0000, 0, 1);
        add_vec(0, 16'h0000, 0, 8'd0, 1, 0, 0, 16'h0000, 0, 0);
        // Basic burst of 4 at full rate.
        add_vec(4, 16'h0001, 1, 8'd4, 1, 0, 0, 16'h0000, 0, 0);
        add_vec(0, 16'h0000, 0, 8'd0, 1, 1, 0, 16'h0000, 1, 0);
        add_vec(0, 16'h0000, 0, 8'd0, 1, 1, 1, 16'h0001, 1, 0);
        add_vec(0, 16'h0000, 0, 8'd0, 1, 1, 1, 16'h0002, 1, 0);
        add_vec(0, 16'h0000, 0, 8'd0, 1, 1, 1, 16'h0003, 1, 0);
        add_vec(0, 16'h0000, 0, 8'd0, 1, 0, 1, 16'h0004, 1, 0);
        add_vec(0, 16'h0000, 0, 8'd0, 1, 0, 0, 16'h0000, 0, 1);
        add_vec(0, 16'h0000, 0, 8'd0, 1, 0, 0, 16'h0000, 0, 0);
        // Backpressure: ready low for 5 cycles, buffer fills to 2 and stalls.
        add_vec(6, 16'h0011, 1, 8'd6, 0, 0, 0, 16'h0000, 0, 0);
        add_vec(0, 16'h0000, 0, 8'd0, 0, 1, 0, 16'h0000, 1, 0);
        add_vec(0, 16'h0000, 0, 8'd0, 0, 1, 1, 16'h0011, 1, 0);
        add_vec(0, 16'h0000, 0, 8'd0, 0, 0, 1, 16'h0011, 1, 0);
        add_vec(0, 16'h0000, 0, 8'd0, 0, 0, 1, 16'h0011, 1, 0);
        add_vec(0, 16'h0000, 0, 8'd0, 1, 0, 1, 16'h0011, 1, 0);
        add_vec(0, 16'h0000, 0, 8'd0, 1, 1, 1, 16'h0012, 1, 0);
        add_vec(0, 16'h0000, 0, 8'd0, 1, 1, 1, 16'h0013, 1, 0);
        add_vec(0, 16'h0000, 0, 8'd0, 1, 1, 1, 16'h0014, 1, 0);
        add_vec(0, 16'h0000, 0, 8'd0, 1, 1, 1, 16'h0015, 1, 0);
        add_vec(0, 16'h0000, 0, 8'd0, 1, 0, 1, 16'h0016, 1, 0);
        add_vec(0, 16'h0000, 0, 8'd0, 1, 0, 0, 16'h0000, 0, 1);
        add_vec(0, 16'h0000, 0, 8'd0, 1, 0, 0, 16'h0000, 0, 0);

        // Reset state.
        i_r_rstn    = 1'b0;
        i_start     = 1'b0;
        i_len       = 8'd0;
        rif.i_ready = 1'b0;
        refresh_fifo();
        repeat (2) @(posedge r_clk);
        #1;
        check_output("rst_inc",   {31'd0, rif.o_r_inc}, 32'd0);
        check_output("rst_valid", {31'd0, rif.o_valid}, 32'd0);
        check_output("rst_data",  {16'd0, rif.o_data},  32'd0);
        check_output("rst_busy",  {31'd0, o_busy},      32'd0);
        check_output("rst_done",  {31'd0, o_done},      32'd0);
`ifdef FIFO_RD_CNT_EN
        check_output("rst_count", {16'd0, rd_count},    32'd0);
`endif
        i_r_rstn = 1'b1;

        // Table-driven cycles.
        foreach (vecs[k]) begin
            apply_stimulus(vecs[k]);
            @(negedge r_clk);
            check_output($sformatf("v%0d_inc", k),  {31'd0, rif.o_r_inc}, {31'd0, vecs[k].e_inc});
            check_output($sformatf("v%0d_valid", k), {31'd0, rif.o_valid}, {31'd0, vecs[k].e_valid});
            if (vecs[k].e_valid) begin
                check_output($sformatf("v%0d_data", k), {16'd0, rif.o_data}, {16'd0, vecs[k].e_data});
            end
            check_output($sformatf("v%0d_busy", k), {31'd0, o_busy}, {31'd0, vecs[k].e_busy});
            check_output($sformatf("v%0d_done", k), {31'd0, o_done}, {31'd0, vecs[k].e_done});
            finish_cycle();
        end
        check_output("table_pops", total_pops, 32'd10);

        // FIFO-empty stall: one word now, two more ten cycles later.
        clear_stats();
        push_words(1, 16'h0031);
        i_start     = 1'b1;
        i_len       = 8'd3;
        rif.i_ready = 1'b1;
        cycle_mon();
        i_start = 1'b0;
        repeat (10) cycle_mon();
        check_output("stall_busy", {31'd0, o_busy}, 32'd1);
        push_words(2, 16'h0032);
        repeat (10) cycle_mon();
        check_output("stall_pops", pops, 32'd3);
        check_output("stall_dones", dones, 32'd1);
        check_got("stall", 3, 16'h0031);

        // Start pulsed again during READ must be ignored.
        clear_stats();
        push_words(7, 16'h0041);
        i_start = 1'b1;
        i_len   = 8'd5;
        cycle_mon();
        i_start = 1'b0;
        repeat (2) cycle_mon();
        i_start = 1'b1;
        i_len   = 8'd2;
        cycle_mon();
        i_start = 1'b0;
        repeat (15) cycle_mon();
        check_output("restart_pops", pops, 32'd5);
        check_output("restart_dones", dones, 32'd1);
        check_output("restart_left", fifo_q.size(), 32'd2);
        check_got("restart", 5, 16'h0041);
        fifo_q.delete();
        refresh_fifo();

`ifdef FIFO_RD_CNT_EN
        check_output("count_total", {16'd0, rd_count}, {16'd0, 16'(total_pops)});
`endif

        // Reset after 2 of 5 pops: everything clears at once, no resume.
        clear_stats();
        push_words(5, 16'h0051);
        i_start = 1'b1;
        i_len   = 8'd5;
        cycle_mon();
        i_start = 1'b0;
        repeat (2) cycle_mon();
        check_output("midrst_pre_pops", pops, 32'd2);
        i_r_rstn = 1'b0;
        #1;
        check_output("midrst_inc",   {31'd0, rif.o_r_inc}, 32'd0);
        check_output("midrst_valid", {31'd0, rif.o_valid}, 32'd0);
        check_output("midrst_data",  {16'd0, rif.o_data},  32'd0);
        check_output("midrst_busy",  {31'd0, o_busy},      32'd0);
        check_output("midrst_done",  {31'd0, o_done},      32'd0);
        repeat (2) @(posedge r_clk);
        #1;
        i_r_rstn   = 1'b1;
        total_pops = 0;
        repeat (8) cycle_mon();
        check_output("midrst_post_pops", pops, 32'd2);
        check_output("midrst_left", fifo_q.size(), 32'd3);
        check_output("midrst_idle", {31'd0, o_busy}, 32'd0);
        fifo_q.delete();
        refresh_fifo();

`ifdef FIFO_RD_CNT_EN
        // 257 bursts of 255 plus one of 2 gives 65537 pops: count wraps to 1.
        for (int b = 0; b < 257; b++) begin
            got_q.delete();
            run_burst(255, 16'h1000);
        end
        run_burst(2, 16'h2000);
        check_output("wrap_pops", total_pops, 32'd65537);
        check_output("wrap_count", {16'd0, rd_count}, 32'h0000_0001);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_miss);
        $finish;
    end

endmodule
